// File: rtl/synchronizer_filtered.sv
// Multi-flop synchronizer per channel, followed by a stability filter and registered rise/fall strobes.
// A level change captured at edge k reaches syncd after edge k+DEPTH+STABLE_CYCLES-1. There is no backpressure.
module synchronizer_filtered #(
  parameter int                DEPTH         = 2,
  parameter int                WIDTH         = 1,
  parameter int                STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] incoming,
  output logic [WIDTH-1:0] syncd,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  generate
    if (DEPTH < 2 || DEPTH > 9) begin : g_bad_depth
      $error("synchronizer_filtered: DEPTH must be within 2..9");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("synchronizer_filtered: WIDTH must be at least 1");
    end
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
      $error("synchronizer_filtered: STABLE_CYCLES must be within 1..65535");
    end
  endgenerate

  // Stage 0 samples the async pins directly, so the whole chain is kept intact and out of IO registers.
  (* preserve, async_reg = "true", altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED; -name FAST_INPUT_REGISTER OFF" *)
  logic [WIDTH-1:0] chain [DEPTH];

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] upd;
  logic [CW-1:0]    cnt [WIDTH];

  assign s = chain[DEPTH-1];

  // A channel commits when s has disagreed with syncd on STABLE_CYCLES consecutive edges, this one included.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (s[i] != syncd[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        chain[j] <= RESET_VALUE;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      syncd      <= RESET_VALUE;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      chain[0] <= incoming;
      for (int j = 1; j < DEPTH; j++) begin
        chain[j] <= chain[j-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == syncd[i] || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
      syncd      <= (syncd & ~upd) | (s & upd);
      rise       <= upd & s;
      fall       <= upd & ~s;
      any_change <= |upd;
    end
  end

endmodule
